// File: rtl/pm_candidate_gen.sv
// pm_candidate_gen: expands L surviving paths into 2L tagged candidate path
// metrics for the PM sorter. Stage 1 forms saturated sums and forces
// inactive/frozen candidates to the sentinel. Stage 2 subtracts the minimum
// valid candidate. Both stages form an elastic valid/ready pipeline.
module pm_candidate_gen #(
    parameter int LIST_SIZE = 4,
    parameter int PM_WIDTH  = 8,
    parameter int LLR_WIDTH = 6,
    parameter int TAG_WIDTH = $clog2(LIST_SIZE) + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              In_valid,
    output logic                              In_ready,
    input  logic [LIST_SIZE*LLR_WIDTH-1:0]    Llr_in,
    input  logic [LIST_SIZE*PM_WIDTH-1:0]     Pm_in,
    input  logic [LIST_SIZE-1:0]              Path_active,
    input  logic                              Frozen,
    output logic                              Out_valid,
    input  logic                              Out_ready,
    output logic [2*LIST_SIZE*PM_WIDTH-1:0]   Cand_pm,
    output logic [2*LIST_SIZE*TAG_WIDTH-1:0]  Cand_tag,
    output logic [PM_WIDTH-1:0]               Norm_offset,
    output logic                              Sat_flag
);

    localparam int NCAND = 2 * LIST_SIZE;
    localparam logic [PM_WIDTH-1:0] PM_MAX     = {PM_WIDTH{1'b1}};
    localparam logic [PM_WIDTH-1:0] PM_SAT     = {{(PM_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [PM_WIDTH:0]   PM_SAT_EXT = {1'b0, PM_SAT};

    // Handshake nets
    logic s1_valid;
    logic s2_valid;
    logic s2_free;
    logic s1_adv;
    logic in_fire;

    // Stage-1 combinational nets
    logic [LLR_WIDTH:0]   llr_ext  [LIST_SIZE];
    logic                 hd       [LIST_SIZE];
    logic [LLR_WIDTH:0]   mag      [LIST_SIZE];
    logic [PM_WIDTH:0]    sum      [LIST_SIZE];
    logic [PM_WIDTH-1:0]  flip_pm  [LIST_SIZE];
    logic                 flip_sat [LIST_SIZE];
    logic [PM_WIDTH-1:0]  cand_d   [NCAND];
    logic                 sat_d;

    // Stage-1 registers
    logic [PM_WIDTH-1:0]  s1_cand  [NCAND];
    logic                 s1_sat;

    // Stage-2 combinational nets
    logic [PM_WIDTH-1:0]  min_val;
    logic                 any_valid;
    logic [PM_WIDTH-1:0]  norm_d;
    logic [PM_WIDTH-1:0]  norm_cand [NCAND];

    // Stage-2 registers
    logic [PM_WIDTH-1:0]  s2_cand  [NCAND];
    logic [TAG_WIDTH-1:0] s2_tag   [NCAND];
    logic [PM_WIDTH-1:0]  s2_norm;
    logic                 sat_q;

    // Stage 2 may accept when empty or draining; stage 1 accepts when empty or advancing.
    always_comb begin
        s2_free  = !s2_valid || Out_ready;
        s1_adv   = s1_valid && s2_free;
        In_ready = !s1_valid || s2_free;
        in_fire  = In_valid && In_ready;
    end

    // Per-path candidate expansion with saturation and sentinel forcing.
    always_comb begin
        sat_d = 1'b0;
        for (int p = 0; p < LIST_SIZE; p++) begin
            llr_ext[p]  = {Llr_in[p*LLR_WIDTH + LLR_WIDTH - 1], Llr_in[p*LLR_WIDTH +: LLR_WIDTH]};
            hd[p]       = llr_ext[p][LLR_WIDTH];
            mag[p]      = hd[p] ? (~llr_ext[p] + 1'b1) : llr_ext[p];
            sum[p]      = {1'b0, Pm_in[p*PM_WIDTH +: PM_WIDTH]}
                        + {{(PM_WIDTH-LLR_WIDTH){1'b0}}, mag[p]};
            flip_sat[p] = (sum[p] > PM_SAT_EXT);
            flip_pm[p]  = flip_sat[p] ? PM_SAT : sum[p][PM_WIDTH-1:0];
            for (int u = 0; u < 2; u++) begin
                if (!Path_active[p] || (Frozen && (u == 1))) begin
                    cand_d[2*p+u] = PM_MAX;
                end else if (u[0] == hd[p]) begin
                    cand_d[2*p+u] = Pm_in[p*PM_WIDTH +: PM_WIDTH];
                end else begin
                    cand_d[2*p+u] = flip_pm[p];
                    if (flip_sat[p]) begin
                        sat_d = 1'b1;
                    end
                end
            end
        end
    end

    // Stage-1 register: loads on every accepted bundle, empties when it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sat   <= 1'b0;
            for (int c = 0; c < NCAND; c++) begin
                s1_cand[c] <= PM_MAX;
            end
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_sat   <= sat_d;
                for (int c = 0; c < NCAND; c++) begin
                    s1_cand[c] <= cand_d[c];
                end
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Minimum over non-sentinel candidates and normalised candidate values.
    always_comb begin
        min_val   = PM_MAX;
        any_valid = 1'b0;
        for (int c = 0; c < NCAND; c++) begin
            if (s1_cand[c] != PM_MAX) begin
                any_valid = 1'b1;
                if (s1_cand[c] < min_val) begin
                    min_val = s1_cand[c];
                end
            end
        end
        norm_d = any_valid ? min_val : '0;
        for (int c = 0; c < NCAND; c++) begin
            norm_cand[c] = (s1_cand[c] == PM_MAX) ? PM_MAX : (s1_cand[c] - norm_d);
        end
    end

    // Stage-2 register: loads from stage 1 when free, holds while the sorter stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_norm  <= '0;
            sat_q    <= 1'b0;
            for (int c = 0; c < NCAND; c++) begin
                s2_cand[c] <= PM_MAX;
                s2_tag[c]  <= TAG_WIDTH'(c);
            end
        end else begin
            if (s1_adv) begin
                s2_valid <= 1'b1;
                s2_norm  <= norm_d;
                sat_q    <= sat_q | s1_sat;
                for (int c = 0; c < NCAND; c++) begin
                    s2_cand[c] <= norm_cand[c];
                    s2_tag[c]  <= TAG_WIDTH'(c);
                end
            end else if (Out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Flatten the stage-2 arrays onto the output buses.
    always_comb begin
        Out_valid   = s2_valid;
        Norm_offset = s2_norm;
        Sat_flag    = sat_q;
        Cand_pm     = '0;
        Cand_tag    = '0;
        for (int c = 0; c < NCAND; c++) begin
            Cand_pm[c*PM_WIDTH +: PM_WIDTH]    = s2_cand[c];
            Cand_tag[c*TAG_WIDTH +: TAG_WIDTH] = s2_tag[c];
        end
    end

endmodule

// File: tb/tb_pm_candidate_gen.sv
// tb_pm_candidate_gen: directed self-checking bench for pm_candidate_gen
// with L=4, PM_WIDTH=8, LLR_WIDTH=6.
module tb_pm_candidate_gen;

    localparam int L  = 4;
    localparam int PW = 8;
    localparam int LW = 6;
    localparam int TW = 3;
    localparam int NC = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              In_valid;
    logic              In_ready;
    logic [L*LW-1:0]   Llr_in;
    logic [L*PW-1:0]   Pm_in;
    logic [L-1:0]      Path_active;
    logic              Frozen;
    logic              Out_valid;
    logic              Out_ready;
    logic [NC*PW-1:0]  Cand_pm;
    logic [NC*TW-1:0]  Cand_tag;
    logic [PW-1:0]     Norm_offset;
    logic              Sat_flag;

    int checks = 0;
    int errors = 0;

    pm_candidate_gen #(.LIST_SIZE(L), .PM_WIDTH(PW), .LLR_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .In_valid(In_valid), .In_ready(In_ready),
        .Llr_in(Llr_in), .Pm_in(Pm_in), .Path_active(Path_active), .Frozen(Frozen),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Cand_pm(Cand_pm),
        .Cand_tag(Cand_tag), .Norm_offset(Norm_offset), .Sat_flag(Sat_flag)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] p0, p1, p2, p3,
                         input logic [5:0] l0, l1, l2, l3,
                         input logic [3:0] act, input logic frz);
        Pm_in       = {p3, p2, p1, p0};
        Llr_in      = {l3, l2, l1, l0};
        Path_active = act;
        Frozen      = frz;
    endtask

    // Presents the driven bundle until accepted (bounded); returns at the negedge after acceptance.
    task automatic accept(output bit ok);
        ok = 1'b0;
        In_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (In_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        In_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1'b0);
        #12;
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", Out_valid); end
        checks++; if (Sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat: got %b expected 0", Sat_flag); end
        checks++; if (Norm_offset !== 8'd0) begin errors++; $display("[TB] FAIL reset_norm: got %0d expected 0", Norm_offset); end
        for (int c = 0; c < NC; c++) begin
            checks++; if (Cand_pm[c*PW +: PW] !== 8'hFF) begin errors++; $display("[TB] FAIL reset_cand%0d: got %0d expected 255", c, Cand_pm[c*PW +: PW]); end
            checks++; if (Cand_tag[c*TW +: TW] !== TW'(c)) begin errors++; $display("[TB] FAIL reset_tag%0d: got %0d expected %0d", c, Cand_tag[c*TW +: TW], c); end
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (In_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", In_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] exp [NC];
        exp = '{8'd0, 8'd4, 8'd5, 8'd3, 8'd5, 8'd15, 8'd38, 8'd7};
        Out_ready = 1'b1;
        drive(0, 3, 5, 7, 6'sd4, -6'sd2, 6'sd10, -6'sd31, 4'hF, 1'b0);
        accept(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_accept: got timeout expected acceptance"); end
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency_early: got %b expected 0", Out_valid); end
        @(negedge clk);
        checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: got %b expected 1", Out_valid); end
        for (int c = 0; c < NC; c++) begin
            checks++; if (Cand_pm[c*PW +: PW] !== exp[c]) begin errors++; $display("[TB] FAIL basic_cand%0d: got %0d expected %0d", c, Cand_pm[c*PW +: PW], exp[c]); end
            checks++; if (Cand_tag[c*TW +: TW] !== TW'(c)) begin errors++; $display("[TB] FAIL basic_tag%0d: got %0d expected %0d", c, Cand_tag[c*TW +: TW], c); end
        end
        checks++; if (Norm_offset !== 8'd0) begin errors++; $display("[TB] FAIL basic_norm: got %0d expected 0", Norm_offset); end
        checks++; if (Sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL basic_sat: got %b expected 0", Sat_flag); end
        @(negedge clk);
    endtask

    task automatic test_frozen_inactive();
        bit ok;
        logic [7:0] exp [NC];
        exp = '{8'd0, 8'd255, 8'd5, 8'd255, 8'd255, 8'd255, 8'd38, 8'd255};
        Out_ready = 1'b1;
        drive(0, 3, 5, 7, 6'sd4, -6'sd2, 6'sd10, -6'sd31, 4'b1011, 1'b1);
        accept(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL frozen_accept: got timeout expected acceptance"); end
        @(negedge clk);
        checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL frozen_valid: got %b expected 1", Out_valid); end
        for (int c = 0; c < NC; c++) begin
            checks++; if (Cand_pm[c*PW +: PW] !== exp[c]) begin errors++; $display("[TB] FAIL frozen_cand%0d: got %0d expected %0d", c, Cand_pm[c*PW +: PW], exp[c]); end
        end
        checks++; if (Norm_offset !== 8'd0) begin errors++; $display("[TB] FAIL frozen_norm: got %0d expected 0", Norm_offset); end
        @(negedge clk);
    endtask

    task automatic test_norm_sat();
        bit ok;
        logic [7:0] exp [NC];
        exp = '{8'd14, 8'd10, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
        Out_ready = 1'b1;
        drive(250, 240, 240, 240, -6'sd32, 6'sd1, 6'sd1, 6'sd1, 4'hF, 1'b0);
        accept(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL norm_accept: got timeout expected acceptance"); end
        @(negedge clk);
        checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL norm_valid: got %b expected 1", Out_valid); end
        for (int c = 0; c < NC; c++) begin
            checks++; if (Cand_pm[c*PW +: PW] !== exp[c]) begin errors++; $display("[TB] FAIL norm_cand%0d: got %0d expected %0d", c, Cand_pm[c*PW +: PW], exp[c]); end
        end
        checks++; if (Norm_offset !== 8'd240) begin errors++; $display("[TB] FAIL norm_offset: got %0d expected 240", Norm_offset); end
        checks++; if (Sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL norm_sat: got %b expected 1", Sat_flag); end
        @(negedge clk);
        checks++; if (Sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL norm_sat_sticky: got %b expected 1", Sat_flag); end
    endtask

    task automatic test_all_inactive();
        bit ok;
        Out_ready = 1'b1;
        drive(1, 2, 3, 4, 6'sd5, 6'sd5, 6'sd5, 6'sd5, 4'b0000, 1'b0);
        accept(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL inactive_accept: got timeout expected acceptance"); end
        @(negedge clk);
        checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL inactive_valid: got %b expected 1", Out_valid); end
        for (int c = 0; c < NC; c++) begin
            checks++; if (Cand_pm[c*PW +: PW] !== 8'hFF) begin errors++; $display("[TB] FAIL inactive_cand%0d: got %0d expected 255", c, Cand_pm[c*PW +: PW]); end
        end
        checks++; if (Norm_offset !== 8'd0) begin errors++; $display("[TB] FAIL inactive_norm: got %0d expected 0", Norm_offset); end
        checks++; if (Sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL inactive_sat: got %b expected 1", Sat_flag); end
        @(negedge clk);
    endtask

    // Six bundles with base PM 10*(k+1) and LLR +1: outputs are [0,1,...], offset identifies the bundle.
    task automatic test_backpressure();
        int  sent = 0;
        int  recv = 0;
        bit  in_fire, out_fire, saw_low, stalled;
        logic [PW-1:0]    held_norm;
        logic [NC*PW-1:0] held_pm;
        bit  pattern [4];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
        saw_low = 1'b0; stalled = 1'b0; held_norm = '0; held_pm = '0;
        for (int cyc = 0; cyc < 80 && recv < 6; cyc++) begin
            Out_ready = pattern[cyc % 4];
            if (sent < 6) begin
                drive(8'(10*(sent+1)), 8'(10*(sent+1)), 8'(10*(sent+1)), 8'(10*(sent+1)),
                      6'sd1, 6'sd1, 6'sd1, 6'sd1, 4'hF, 1'b0);
                In_valid = 1'b1;
            end else begin
                In_valid = 1'b0;
            end
            #1;
            if (In_valid && !In_ready) saw_low = 1'b1;
            if (stalled) begin
                checks++; if (Norm_offset !== held_norm) begin errors++; $display("[TB] FAIL bp_stable_norm: got %0d expected %0d", Norm_offset, held_norm); end
                checks++; if (Cand_pm !== held_pm) begin errors++; $display("[TB] FAIL bp_stable_pm: got %h expected %h", Cand_pm, held_pm); end
            end
            in_fire  = In_valid && In_ready;
            out_fire = Out_valid && Out_ready;
            stalled  = Out_valid && !Out_ready;
            held_norm = Norm_offset;
            held_pm   = Cand_pm;
            if (out_fire) begin
                checks++; if (Norm_offset !== 8'(10*(recv+1))) begin errors++; $display("[TB] FAIL bp_order%0d: got %0d expected %0d", recv, Norm_offset, 10*(recv+1)); end
                checks++; if (Cand_pm !== 64'h0100010001000100) begin errors++; $display("[TB] FAIL bp_data%0d: got %h expected 0100010001000100", recv, Cand_pm); end
                recv++;
            end
            @(posedge clk);
            if (in_fire) sent++;
            @(negedge clk);
        end
        In_valid = 1'b0;
        checks++; if (recv != 6) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 6", recv); end
        checks++; if (!saw_low) begin errors++; $display("[TB] FAIL bp_in_ready_drop: got no stall expected In_ready low"); end
        Out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got %b expected 0", Out_valid); end
    endtask

    task automatic test_throughput();
        int sent = 0;
        int recv = 0;
        int first_out = -1;
        int last_out = -1;
        bit in_fire;
        Out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (sent < 6) begin
                drive(8'(20*(sent+1)), 8'(20*(sent+1)), 8'(20*(sent+1)), 8'(20*(sent+1)),
                      6'sd1, 6'sd1, 6'sd1, 6'sd1, 4'hF, 1'b0);
                In_valid = 1'b1;
            end else begin
                In_valid = 1'b0;
            end
            #1;
            if (In_valid) begin
                checks++; if (In_ready !== 1'b1) begin errors++; $display("[TB] FAIL tp_in_ready%0d: got %b expected 1", cyc, In_ready); end
            end
            in_fire = In_valid && In_ready;
            if (Out_valid) begin
                checks++; if (Norm_offset !== 8'(20*(recv+1))) begin errors++; $display("[TB] FAIL tp_order%0d: got %0d expected %0d", recv, Norm_offset, 20*(recv+1)); end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                recv++;
            end
            @(posedge clk);
            if (in_fire) sent++;
            @(negedge clk);
        end
        In_valid = 1'b0;
        checks++; if (recv != 6) begin errors++; $display("[TB] FAIL tp_count: got %0d expected 6", recv); end
        checks++; if (last_out - first_out != 5) begin errors++; $display("[TB] FAIL tp_rate: got span %0d expected 5", last_out - first_out); end
        checks++; if (first_out != 2) begin errors++; $display("[TB] FAIL tp_latency: got cycle %0d expected 2", first_out); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        Out_ready = 1'b0;
        drive(250, 240, 240, 240, -6'sd32, 6'sd1, 6'sd1, 6'sd1, 4'hF, 1'b0);
        accept(ok);
        drive(1, 1, 1, 1, 6'sd1, 6'sd1, 6'sd1, 6'sd1, 4'hF, 1'b0);
        accept(ok);
        #1;
        checks++; if (Out_valid !== 1'b1 || In_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_full: got valid=%b ready=%b expected 1 0", Out_valid, In_ready); end
        checks++; if (Sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL rmid_sat_before: got %b expected 1", Sat_flag); end
        rst_n = 1'b0;
        #1;
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_out_valid: got %b expected 0", Out_valid); end
        checks++; if (Sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL rmid_sat: got %b expected 0", Sat_flag); end
        checks++; if (Cand_pm !== {NC*PW{1'b1}}) begin errors++; $display("[TB] FAIL rmid_cand: got %h expected all ff", Cand_pm); end
        @(negedge clk); rst_n = 1'b1; Out_ready = 1'b1;
        @(negedge clk);
        checks++; if (In_ready !== 1'b1 || Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_release: got ready=%b valid=%b expected 1 0", In_ready, Out_valid); end
        drive(0, 3, 5, 7, 6'sd4, -6'sd2, 6'sd10, -6'sd31, 4'hF, 1'b0);
        accept(ok);
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_latency_early: got %b expected 0", Out_valid); end
        @(negedge clk);
        checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_latency: got %b expected 1", Out_valid); end
        checks++; if (Cand_pm !== {8'd7, 8'd38, 8'd15, 8'd5, 8'd3, 8'd5, 8'd4, 8'd0}) begin errors++; $display("[TB] FAIL rmid_data: got %h expected 07260f0503050400", Cand_pm); end
        @(negedge clk);
    endtask

    // Runs each scenario in order, then prints the summary.
    initial begin
        test_reset();
        test_basic();
        test_frozen_inactive();
        test_norm_sat();
        test_all_inactive();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
